// File: rtl/wrap_counter.sv
// Up-counter with a run-time terminal value and a wrap strobe.
// Cascade by feeding one instance's done into the next one's enable.
module wrap_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] max,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  logic at_top;

  // q >= max, not q == max, so that a max lowered below q
  // still forces a wrap rather than a run to all-ones.
  assign at_top = (q >= max);

  // Hold, count or wrap on each enabled edge; async clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (enable) begin
      if (at_top) begin
        q <= '0;
      end else begin
        q <= q + WIDTH'(1);
      end
    end
  end

  assign done = enable && at_top;

endmodule

// File: tb/tb_wrap_counter.sv
// Directed bench for wrap_counter.
// Single DUT plus a two-stage cascade.
module tb_wrap_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [9:0] max;
  logic       done;
  logic [9:0] q;

  logic       cas_en;
  logic [9:0] max_a;
  logic [9:0] max_b;
  logic       done_a;
  logic       done_b;
  logic [9:0] qa;
  logic [9:0] qb;

  int n_chk;
  int n_fail;

  wrap_counter #(.WIDTH(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .max    (max),
    .done   (done),
    .q      (q)
  );

  wrap_counter #(.WIDTH(10)) u_a (
    .clk    (clk),
    .reset  (reset),
    .enable (cas_en),
    .max    (max_a),
    .done   (done_a),
    .q      (qa)
  );

  wrap_counter #(.WIDTH(10)) u_b (
    .clk    (clk),
    .reset  (reset),
    .enable (done_a),
    .max    (max_b),
    .done   (done_b),
    .q      (qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cas_restart(input logic [9:0] a,
                             input logic [9:0] b);
    cas_en = 1'b0;
    max_a  = a;
    max_b  = b;
    reset  = 1'b0;
    tick();
    reset  = 1'b1;
    cas_en = 1'b1;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    enable = 1'b0;
    max    = 10'd5;
    cas_en = 1'b0;
    max_a  = 10'd3;
    max_b  = 10'd2;
    #12;
    chk("rst_q", 32'(q), 0);
    chk("rst_done_off", 32'(done), 0);
    max = 10'd0;
    enable = 1'b1;
    #1;
    chk("rst_done_max0", 32'(done), 1);
    max = 10'd5;
    #1;
    chk("rst_done_max5", 32'(done), 0);

    // release and wrap at 5
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("wrap_q", 32'(q), 32'(i % 6));
      chk("wrap_done", 32'(done), (i % 6 == 5) ? 1 : 0);
    end

    // async reset mid-count at q=3
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_q", 32'(q), 3);
    reset = 1'b0;
    #1;
    chk("async_q", 32'(q), 0);
    chk("async_done", 32'(done), 0);
    tick();
    chk("held_rst_q", 32'(q), 0);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("post_rst_q", 32'(q), 32'(i % 6));
    end

    // enable gating from q=2
    tick();
    tick();
    chk("gate_start", 32'(q), 2);
    begin
      logic [3:0] en_seq;
      int         q_exp [4];
      en_seq = 4'b1001;
      q_exp  = '{3, 3, 3, 4};
      for (int i = 0; i < 4; i++) begin
        enable = en_seq[3-i];
        #1;
        chk("gate_done", 32'(done), 0);
        tick();
        chk("gate_q", 32'(q), 32'(q_exp[i]));
      end
    end
    enable = 1'b1;
    tick();
    chk("top_q", 32'(q), 5);
    chk("top_done", 32'(done), 1);
    enable = 1'b0;
    #1;
    chk("top_hold_done", 32'(done), 0);
    tick();
    chk("top_hold_q", 32'(q), 5);
    enable = 1'b1;
    #1;
    chk("top_resume_done", 32'(done), 1);
    tick();
    chk("top_resume_q", 32'(q), 0);

    // max = 0
    max = 10'd0;
    for (int i = 0; i < 4; i++) begin
      enable = i[0];
      #1;
      chk("max0_done", 32'(done), 32'(i[0]));
      tick();
      chk("max0_q", 32'(q), 0);
    end

    // max = all-ones, full 1024-cycle period
    enable = 1'b1;
    max = 10'd1023;
    for (int i = 1; i <= 1023; i++) begin
      tick();
      if (i == 512) chk("full_mid", 32'(q), 512);
    end
    chk("full_top_q", 32'(q), 1023);
    chk("full_top_done", 32'(done), 1);
    tick();
    chk("full_wrap_q", 32'(q), 0);
    chk("full_wrap_done", 32'(done), 0);

    // runtime max change
    max = 10'd10;
    for (int i = 0; i < 7; i++) tick();
    chk("rt_q7", 32'(q), 7);
    chk("rt_done7", 32'(done), 0);
    max = 10'd4;
    #1;
    chk("rt_lower_done", 32'(done), 1);
    tick();
    chk("rt_lower_q", 32'(q), 0);
    tick();
    tick();
    chk("rt_q2", 32'(q), 2);
    max = 10'd9;
    for (int i = 3; i <= 9; i++) begin
      tick();
      chk("rt_raise_q", 32'(q), 32'(i));
      chk("rt_raise_done", 32'(done), (i == 9) ? 1 : 0);
    end
    tick();
    chk("rt_raise_wrap", 32'(q), 0);

    // short cascade: 4 x 3 = 12 clocks per B period
    cas_restart(10'd3, 10'd2);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) chk("cs_b0", 32'(qb), 0);
      if (i == 4) chk("cs_b1", 32'(qb), 1);
      if (i == 11) chk("cs_bdone", 32'(done_b), 1);
      if (i == 12) chk("cs_bwrap", 32'(qb), 0);
    end

    // VGA-sized cascade, first three line periods
    cas_restart(10'd799, 10'd524);
    for (int i = 1; i <= 2400; i++) begin
      tick();
      if (i == 799) begin
        chk("vga_a_top", 32'(qa), 799);
        chk("vga_a_done", 32'(done_a), 1);
        chk("vga_b0", 32'(qb), 0);
      end
      if (i == 800) chk("vga_b1", 32'(qb), 1);
      if (i == 1599) chk("vga_b1_hold", 32'(qb), 1);
      if (i == 2400) chk("vga_b3", 32'(qb), 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
